change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Bundle of operand, coin-mechanism and status signals for change_dispenser.
// The master side is the vending controller / coin mechanism; the slave is the dispenser.
interface change_dispenser_if;
   logic       start;
   logic [7:0] paid;
   logic [7:0] price;
   logic       coin_ack;
   logic       clear;
   logic [2:0] coin_req;
   logic       busy;
   logic       done;
   logic       err_short;
   logic       fault;
   logic [4:0] coin_count;
   logic [7:0] change_left;

   modport master (
      output start, paid, price, coin_ack, clear,
      input  coin_req, busy, done, err_short, fault, coin_count, change_left
   );

   modport slave (
      input  start, paid, price, coin_ack, clear,
      output coin_req, busy, done, err_short, fault, coin_count, change_left
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: ejects $10/$5/$1 coins one at a time through a
// request/acknowledge coin mechanism, with inter-coin gap and ack timeout.
module change_dispenser #(
   parameter int GAP     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   change_dispenser_if.slave bus,
   output logic [2:0]        dbg_state_o
);

   // coin_ack handshake: coin_req is held one-hot and stable in WAIT_ACK; every
   // rising edge with coin_ack=1 in that state consumes exactly one coin.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CALC     = 3'd1,
      ISSUE    = 3'd2,
      WAIT_ACK = 3'd3,
      GAP_WAIT = 3'd4,
      DONE     = 3'd5,
      FAULT    = 3'd6
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

   state_t     state_q;
   logic [7:0] paid_q;
   logic [7:0] price_q;
   logic [2:0] coin_req_q;
   logic       done_q;
   logic       err_short_q;
   logic       fault_q;
   logic [4:0] coin_count_q;
   logic [7:0] change_left_q;
   logic [7:0] tmo_q;
   logic [3:0] gap_q;

   logic [2:0] next_coin_d;
   logic [7:0] coin_val_d;

   // Largest denomination not exceeding the change still owed.
   always_comb begin
      next_coin_d = 3'b001;
      if (change_left_q >= 8'd10)
         next_coin_d = 3'b100;
      else if (change_left_q >= 8'd5)
         next_coin_d = 3'b010;
   end

   always_comb begin
      coin_val_d = 8'd1;
      if (coin_req_q[2])
         coin_val_d = 8'd10;
      else if (coin_req_q[1])
         coin_val_d = 8'd5;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         paid_q        <= 8'd0;
         price_q       <= 8'd0;
         coin_req_q    <= 3'b000;
         done_q        <= 1'b0;
         err_short_q   <= 1'b0;
         fault_q       <= 1'b0;
         coin_count_q  <= 5'd0;
         change_left_q <= 8'd0;
         tmo_q         <= 8'd0;
         gap_q         <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  paid_q       <= bus.paid;
                  price_q      <= bus.price;
                  coin_count_q <= 5'd0;
                  err_short_q  <= 1'b0;
                  state_q      <= CALC;
               end
            end
            CALC: begin
               if (paid_q < price_q) begin
                  err_short_q   <= 1'b1;
                  change_left_q <= 8'd0;
                  done_q        <= 1'b1;
                  state_q       <= DONE;
               end else begin
                  change_left_q <= paid_q - price_q;
                  state_q       <= ISSUE;
               end
            end
            ISSUE: begin
               if (change_left_q == 8'd0) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  coin_req_q <= next_coin_d;
                  tmo_q      <= 8'd0;
                  state_q    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               // An ack on the final timeout edge still counts as a delivered coin.
               if (bus.coin_ack) begin
                  coin_req_q    <= 3'b000;
                  change_left_q <= change_left_q - coin_val_d;
                  coin_count_q  <= coin_count_q + 5'd1;
                  gap_q         <= 4'd0;
                  state_q       <= GAP_WAIT;
               end else if (tmo_q == TMO_LAST) begin
                  coin_req_q <= 3'b000;
                  fault_q    <= 1'b1;
                  state_q    <= FAULT;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            GAP_WAIT: begin
               if (gap_q == GAP_LAST)
                  state_q <= ISSUE;
               else
                  gap_q <= gap_q + 4'd1;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            FAULT: begin
               if (bus.clear) begin
                  fault_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.coin_req    = coin_req_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.err_short   = err_short_q;
   assign bus.fault       = fault_q;
   assign bus.coin_count  = coin_count_q;
   assign bus.change_left = change_left_q;
   assign dbg_state_o     = state_q;

endmodule
